// File: rtl/bht_pkg.sv
// Shared types and the 2-bit saturating counter step for the branch history table.
package bht_pkg;

    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} sat2_t;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} bht_fsm_t;

    // Step a counter toward taken or not-taken, saturating at both ends.
    function automatic sat2_t sat_next(sat2_t s, logic taken);
        sat2_t r;
        case (s)
            SNT:     r = taken ? WNT : SNT;
            WNT:     r = taken ? WT  : SNT;
            WT:      r = taken ? ST  : WNT;
            default: r = taken ? ST  : WT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bht_if.sv
// Fetch/Execute-side signal bundle of the branch history table controller.
// master = pipeline side, slave = bht_ctrl side.
interface bht_if #(
    parameter int IDX_W = 6
);
    logic [31:0]      PCF;
    logic             PredTakenF;
    logic [IDX_W-1:0] IdxF;
    logic             BranchE;
    logic             ZeroE;
    logic             StallE;
    logic             PredTakenE;
    logic [IDX_W-1:0] IdxE;
    logic [31:0]      PCTargetE;
    logic [31:0]      PCPlus4E;
    logic             MispredictE;
    logic [31:0]      RedirectPCE;
    logic             Ready;

    modport master (
        output PCF, BranchE, ZeroE, StallE, PredTakenE, IdxE, PCTargetE, PCPlus4E,
        input  PredTakenF, IdxF, MispredictE, RedirectPCE, Ready
    );

    modport slave (
        input  PCF, BranchE, ZeroE, StallE, PredTakenE, IdxE, PCTargetE, PCPlus4E,
        output PredTakenF, IdxF, MispredictE, RedirectPCE, Ready
    );
endinterface

// File: rtl/bht_array.sv
// Counter storage: 2**IDX_W x 2 bits, two async read ports (fetch lookup and
// execute read-modify-write), one sync write port muxed between init and update.
module bht_array #(
    parameter int          IDX_W   = 6,
    parameter logic [1:0]  INIT_ST = 2'b01
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] raddr_f,
    output logic [1:0]       rdata_f,
    input  logic [IDX_W-1:0] raddr_e,
    output logic [1:0]       rdata_e,
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_addr,
    input  logic             upd_we,
    input  logic [IDX_W-1:0] upd_addr,
    input  logic [1:0]       upd_data
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0] mem [DEPTH];

    // Single write port: initialisation owns it; updates only occur once Ready.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= INIT_ST;
        end else if (upd_we) begin
            mem[upd_addr] <= upd_data;
        end
    end

    assign rdata_f = mem[raddr_f];
    assign rdata_e = mem[raddr_e];

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: init sequencing, fetch prediction with
// same-cycle update bypass, execute-stage counter update and mispredict redirect.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_ctrl
    import bht_pkg::*;
#(
    parameter int         IDX_W   = 6,
    parameter logic [1:0] INIT_ST = 2'b01
) (
    input  logic clk,
    input  logic reset,
    bht_if.slave bus
);
    bht_fsm_t         state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic             init_we;
    logic             active;
    logic             upd_e;
    logic [IDX_W-1:0] idx_f;
    logic [1:0]       rd_f, rd_e;
    sat2_t            nxt_e;
    logic             pred_f;
    logic             unused_pc;

    // State and init pointer; reset restarts initialisation from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    // INIT walks every entry once, then RUN holds until the next reset.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        init_we = 1'b0;
        case (state)
            INIT: begin
                init_we = ~reset;
                ptr_n   = ptr + 1'b1;
                if (ptr == '1) begin
                    state_n = RUN;
                end
            end
            RUN:     state_n = RUN;
            default: state_n = INIT;
        endcase
    end

    assign bus.Ready = (state == RUN);
    assign active    = bus.Ready & ~reset;
    assign upd_e     = active & bus.BranchE & ~bus.StallE;

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Global history shifts in each committed outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (upd_e) begin
            ghr <= {ghr[IDX_W-2:0], bus.ZeroE};
        end
    end

    assign idx_f = bus.PCF[IDX_W+1:2] ^ ghr;
`else
    assign idx_f = bus.PCF[IDX_W+1:2];
`endif

    assign unused_pc = ^{bus.PCF[31:IDX_W+2], bus.PCF[1:0]};
    assign bus.IdxF  = idx_f;

    bht_array #(
        .IDX_W  (IDX_W),
        .INIT_ST(INIT_ST)
    ) u_array (
        .clk      (clk),
        .raddr_f  (idx_f),
        .rdata_f  (rd_f),
        .raddr_e  (bus.IdxE),
        .rdata_e  (rd_e),
        .init_we  (init_we),
        .init_addr(ptr),
        .upd_we   (upd_e),
        .upd_addr (bus.IdxE),
        .upd_data (nxt_e)
    );

    assign nxt_e = sat_next(sat2_t'(rd_e), bus.ZeroE);

    // Prediction; forwards the counter being written this cycle to the same index.
    always_comb begin
        pred_f = 1'b0;
        if (active) begin
            if (upd_e && (bus.IdxE == idx_f)) begin
                pred_f = nxt_e[1];
            end else begin
                pred_f = rd_f[1];
            end
        end
    end

    assign bus.PredTakenF  = pred_f;
    assign bus.MispredictE = active & bus.BranchE & (bus.ZeroE != bus.PredTakenE);
    assign bus.RedirectPCE = bus.ZeroE ? bus.PCTargetE : bus.PCPlus4E;

endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl: init timing (IDX_W=2 instance), reset
// during init, then a table of resolve/predict vectors on an IDX_W=3 instance.
module tb_bht_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    bht_if #(.IDX_W(3)) bus  ();
    bht_if #(.IDX_W(2)) bus2 ();

    bht_ctrl #(.IDX_W(3), .INIT_ST(2'b01)) dut  (.clk(clk), .reset(rst_a), .bus(bus));
    bht_ctrl #(.IDX_W(2), .INIT_ST(2'b01)) dut2 (.clk(clk), .reset(rst_b), .bus(bus2));

    localparam logic [31:0] TGT = 32'h0000_0100;
    localparam logic [31:0] P4  = 32'h0000_0204;

    typedef struct {
        logic [2:0]  fidx;
        logic        br;
        logic        z;
        logic        st;
        logic        pe;
        logic [2:0]  eidx;
        logic        xpred;
        logic        xmis;
        logic [31:0] xrpc;
    } vec_t;

    typedef struct {
        logic [2:0]  idx;
        logic        pred;
        logic        mis;
        logic [31:0] rpc;
        int          row;
    } exp_t;

    vec_t vt[21];
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(int f, int br, int z, int st, int pe, int e, int xp, int xm);
        vec_t v;
        v.fidx  = 3'(f);
        v.br    = 1'(br);
        v.z     = 1'(z);
        v.st    = 1'(st);
        v.pe    = 1'(pe);
        v.eidx  = 3'(e);
        v.xpred = 1'(xp);
        v.xmis  = 1'(xm);
        v.xrpc  = (z != 0) ? TGT : P4;
        return v;
    endfunction

    task automatic drive(input logic [2:0] f, input logic br, input logic z,
                         input logic st, input logic pe, input logic [2:0] e);
        bus.PCF        = 32'h0000_1000 | {27'd0, f, 2'b00};
        bus.BranchE    = br;
        bus.ZeroE      = z;
        bus.StallE     = st;
        bus.PredTakenE = pe;
        bus.IdxE       = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;

        // fidx br z st pe eidx | pred mis
        vt[0]  = mk(5, 1, 1, 0, 0, 5, 1, 1);
        vt[1]  = mk(5, 1, 1, 0, 1, 5, 1, 0);
        vt[2]  = mk(5, 1, 1, 0, 1, 5, 1, 0);
        vt[3]  = mk(5, 0, 0, 0, 0, 0, 1, 0);
        vt[4]  = mk(2, 1, 0, 0, 0, 2, 0, 0);
        vt[5]  = mk(2, 1, 0, 0, 0, 2, 0, 0);
        vt[6]  = mk(2, 1, 0, 0, 0, 2, 0, 0);
        vt[7]  = mk(2, 1, 1, 0, 0, 2, 0, 1);
        vt[8]  = mk(2, 0, 0, 0, 0, 0, 0, 0);
        vt[9]  = mk(2, 1, 1, 0, 0, 2, 1, 1);
        vt[10] = mk(0, 1, 1, 0, 0, 0, 1, 1);
        vt[11] = mk(1, 1, 0, 0, 0, 1, 0, 0);
        vt[12] = mk(4, 1, 0, 0, 1, 3, 0, 1);
        vt[13] = mk(3, 1, 1, 0, 0, 6, 0, 1);
        vt[14] = mk(6, 0, 0, 0, 0, 0, 1, 0);
        vt[15] = mk(7, 1, 1, 1, 0, 7, 0, 1);
        vt[16] = mk(7, 1, 1, 1, 0, 7, 0, 1);
        vt[17] = mk(7, 1, 1, 0, 0, 7, 1, 1);
        vt[18] = mk(7, 0, 0, 0, 0, 0, 1, 0);
        vt[19] = mk(7, 1, 0, 0, 1, 7, 0, 1);
        vt[20] = mk(7, 0, 0, 0, 0, 0, 0, 0);

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        bus.PCTargetE   = TGT;
        bus.PCPlus4E    = P4;
        bus2.PCF        = '0;
        bus2.BranchE    = 1'b0;
        bus2.ZeroE      = 1'b0;
        bus2.StallE     = 1'b0;
        bus2.PredTakenE = 1'b0;
        bus2.IdxE       = '0;
        bus2.PCTargetE  = TGT;
        bus2.PCPlus4E   = P4;
        tick();
        tick();

        check("b_ready_in_reset", 32'(bus2.Ready), 32'd0);
        check("b_pred_in_reset", 32'(bus2.PredTakenF), 32'd0);

        // Small table: Ready after exactly 4 cycles, no prediction meanwhile.
        rst_b = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus2.PCF = 32'(k % 4) << 2;
            tick();
            check($sformatf("b_ready_cyc%0d", k), 32'(bus2.Ready), (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) check($sformatf("b_pred_init_cyc%0d", k), 32'(bus2.PredTakenF), 32'd0);
        end

        // Every entry holds 01: plain read predicts 0, a taken step predicts 1.
        for (int i = 0; i < 4; i++) begin
            bus2.PCF     = 32'(i) << 2;
            bus2.BranchE = 1'b0;
            #1;
            check($sformatf("b_entry%0d_read", i), 32'(bus2.PredTakenF), 32'd0);
            bus2.BranchE    = 1'b1;
            bus2.ZeroE      = 1'b1;
            bus2.PredTakenE = 1'b1;
            bus2.IdxE       = 2'(i);
            #1;
            check($sformatf("b_entry%0d_step", i), 32'(bus2.PredTakenF), 32'd1);
            tick();
        end
        bus2.BranchE = 1'b0;

        // Reset at init ptr=7 restarts the full walk; branches during init are ignored.
        rst_a = 1'b0;
        drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 1; k <= 7; k++) tick();
        check("a_ready_ptr7", 32'(bus.Ready), 32'd0);
        rst_a = 1'b1;
        #1;
        check("a_mis_in_reset", 32'(bus.MispredictE), 32'd0);
        check("a_pred_in_reset", 32'(bus.PredTakenF), 32'd0);
        tick();
        rst_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("a_ready_cyc%0d", k), 32'(bus.Ready), (k == 8) ? 32'd1 : 32'd0);
            if (k < 8) begin
                check($sformatf("a_mis_init_cyc%0d", k), 32'(bus.MispredictE), 32'd0);
                check($sformatf("a_pred_init_cyc%0d", k), 32'(bus.PredTakenF), 32'd0);
            end else begin
                bus.BranchE = 1'b0;
            end
        end

        // Entry 0 must still be 01: read 0, taken -> 10, not-taken -> back to 01.
        #1;
        check("a_entry0_read", 32'(bus.PredTakenF), 32'd0);
        drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
        #1;
        check("a_entry0_taken", 32'(bus.PredTakenF), 32'd1);
        tick();
        drive(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        #1;
        check("a_entry0_restore", 32'(bus.PredTakenF), 32'd0);
        tick();

        // Table-driven section with a scoreboard of expected outputs.
        for (int r = 0; r < 21; r++) begin
            drive(vt[r].fidx, vt[r].br, vt[r].z, vt[r].st, vt[r].pe, vt[r].eidx);
            e.idx  = vt[r].fidx;
            e.pred = vt[r].xpred;
            e.mis  = vt[r].xmis;
            e.rpc  = vt[r].xrpc;
            e.row  = r;
            sb.push_back(e);
            #1;
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("row%0d_idxf", e.row), 32'(bus.IdxF), 32'(e.idx));
                check($sformatf("row%0d_pred", e.row), 32'(bus.PredTakenF), 32'(e.pred));
                check($sformatf("row%0d_mis", e.row), 32'(bus.MispredictE), 32'(e.mis));
                if (e.mis) check($sformatf("row%0d_rpc", e.row), bus.RedirectPCE, e.rpc);
            end
            tick();
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        bus.BranchE = 1'b0;

`ifdef BHT_GSHARE_EN
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int k = 0; k < 20 && !bus.Ready; k++) tick();
        check("g_ready", 32'(bus.Ready), 32'd1);
        drive(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        #1;
        check("g_idxf_ghr0", 32'(bus.IdxF), 32'd1);
        drive(3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
        tick();
        drive(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        drive(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        #1;
        check("g_idxf_ghr010", 32'(bus.IdxF), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
